mdu_ex: RTL and testbench

- Iterative RV32M multiply/divide unit in the Execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the forwarded EX operands, funct3 and Rd of an M-extension instruction.
- Asserts busy to the hazard unit so ID/EX and earlier stages stall, then presents a registered result for one cycle so the pipeline can carry it into EX/MEM.

---
 rtl/mdu_ex.sv | 183 ++++++++++++++++++
 tb/tb_mdu_ex.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ex.sv
// Iterative RV32M multiply/divide unit for the EX stage (radix-2 shift-add / restoring divide).
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish at accept.
module mdu_ex #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MduResultE,
  output logic [4:0]      MduRdE
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   operand;
  logic [XLEN-1:0]   dividend;
  logic              neg_res, neg_rem, div_zero, div_ovf;

  logic              accept, last_step;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              in_div_zero, in_div_ovf;
  logic              early_hit;
  logic [XLEN-1:0]   early_result;

  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum, rem_trial, rem_diff;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, rem, final_result;

  assign accept    = (state == IDLE) && start && !clear;
  assign last_step = (state == CALC) && (count == CW'(XLEN-1));

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:         a_signed = 1'b1;
      3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:        ;
    endcase
  end

  assign sign_a      = a_signed & SrcAE[XLEN-1];
  assign sign_b      = b_signed & SrcBE[XLEN-1];
  assign mag_a       = sign_a ? -SrcAE : SrcAE;
  assign mag_b       = sign_b ? -SrcBE : SrcBE;
  assign in_div_zero = (SrcBE == '0);
  assign in_div_ovf  = funct3[2] & ~funct3[0] & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);

`ifdef MDU_EARLY_OUT_EN
  always_comb begin
    early_hit    = 1'b0;
    early_result = '0;
    if (funct3[2]) begin
      if (in_div_zero) begin
        early_hit    = 1'b1;
        early_result = funct3[1] ? SrcAE : '1;
      end else if (in_div_ovf) begin
        early_hit    = 1'b1;
        early_result = funct3[1] ? '0 : SrcAE;
      end
    end else if ((SrcAE == '0) || (SrcBE == '0)) begin
      early_hit = 1'b1;
    end
  end
`else
  assign early_hit    = 1'b0;
  assign early_result = '0;
`endif

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient bits}
  assign addend    = acc[0] ? operand : '0;
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
  assign rem_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign rem_diff  = rem_trial - {1'b0, operand};

  always_comb begin
    if (op[2]) begin
      if (rem_diff[XLEN])
        acc_step = {rem_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_step = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = neg_res ? -acc_step : acc_step;
    quo  = neg_res ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_rem ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (div_zero) begin
      quo = '1;
      rem = dividend;
    end else if (div_ovf) begin
      quo = {1'b1, {(XLEN-1){1'b0}}};
      rem = '0;
    end
    case (op)
      3'b000:                 final_result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_result = quo;
      default:                final_result = rem;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = early_hit ? DONE : CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_comb begin
    busy = accept | (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      op         <= '0;
      acc        <= '0;
      operand    <= '0;
      dividend   <= '0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero   <= 1'b0;
      div_ovf    <= 1'b0;
      MduResultE <= '0;
      MduRdE     <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (accept) begin
      op       <= funct3;
      MduRdE   <= RdE;
      count    <= '0;
      neg_res  <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= funct3[2] & in_div_zero;
      div_ovf  <= in_div_ovf;
      dividend <= SrcAE;
      if (funct3[2]) begin
        acc     <= {{XLEN{1'b0}}, mag_a};
        operand <= mag_b;
      end else begin
        acc     <= {{XLEN{1'b0}}, mag_b};
        operand <= mag_a;
      end
      if (early_hit) MduResultE <= early_result;
    end else if (state == CALC) begin
      acc   <= acc_step;
      count <= count + 1'b1;
      if (last_step) MduResultE <= final_result;
    end
  end

endmodule

// File: tb/tb_mdu_ex.sv
// Directed bench for mdu_ex; an arithmetic RV32M model supplies the result checked on every done pulse.
module tb_mdu_ex;
  localparam int XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, clear, start;
  logic [2:0]  funct3;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        busy, done;
  logic [31:0] MduResultE;
  logic [4:0]  MduRdE;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
  } exp_t;
  exp_t expQ[$];
  exp_t cur;

  mdu_ex #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .clear(clear), .start(start), .funct3(funct3),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE), .busy(busy), .done(done),
    .MduResultE(MduResultE), .MduRdE(MduRdE)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int ia, ib;
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isEarly(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit corner;
    if (f[2]) corner = (b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    else      corner = (a == 0) || (b == 0);
    return EARLY && corner;
  endfunction

  // Every done pulse must correspond to one queued expectation
  always @(negedge clock) begin
    if (reset && done) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: done=1, expected 0");
      end else begin
        cur = expQ.pop_front();
        checkOutput("result", MduResultE, cur.result);
        checkOutput("rd", {27'b0, MduRdE}, {27'b0, cur.rd});
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit);
    int cyc, wantCyc;
    bit busyDrop;
    exp_t e;
    checkOutput({name, "_model"}, refResult(f, a, b), lit);
    e.result = refResult(f, a, b);
    e.rd = rd;
    expQ.push_back(e);
    wantCyc = isEarly(f, a, b) ? 1 : XLEN + 1;
    @(posedge clock); #1;
    start = 1'b1; funct3 = f; SrcAE = a; SrcBE = b; RdE = rd;
    @(negedge clock);
    checkOutput({name, "_busy0"}, {31'b0, busy}, 32'd1);
    @(posedge clock); #1;
    start = 1'b0; SrcAE = $urandom; SrcBE = $urandom; RdE = 5'($urandom); funct3 = 3'($urandom);
    cyc = 1;
    busyDrop = 1'b0;
    forever begin
      @(negedge clock);
      if (done || cyc > 3 * XLEN) break;
      if (!busy) busyDrop = 1'b1;
      cyc++;
    end
    checkOutput({name, "_latency"}, 32'(cyc), 32'(wantCyc));
    checkOutput({name, "_busydrop"}, {31'b0, busyDrop}, 32'd0);
    checkOutput({name, "_busydone"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int dones, doneCyc;
    reset = 1'b0; clear = 1'b0; start = 1'b0; funct3 = 3'd0; SrcAE = 32'd0; SrcBE = 32'd0; RdE = 5'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_result", MduResultE, 32'd0);
    checkOutput("rst_rd", {27'b0, MduRdE}, 32'd0);
    reset = 1'b1;

    applyStimulus("mul",       3'd0, 32'hFFFFFFFF, 32'h00000002, 5'd1,  32'hFFFFFFFE);
    applyStimulus("mulh",      3'd1, 32'hFFFFFFFF, 32'h00000002, 5'd2,  32'hFFFFFFFF);
    applyStimulus("mulhsu",    3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF);
    applyStimulus("mulhu",     3'd3, 32'hFFFFFFFF, 32'h00000002, 5'd4,  32'h00000001);
    applyStimulus("mulh_max",  3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd5,  32'h3FFFFFFF);
    applyStimulus("mulhsu_mn", 3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000);
    applyStimulus("mul_zero",  3'd0, 32'h00000000, 32'h00000005, 5'd7,  32'h00000000);
    applyStimulus("div",       3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFD);
    applyStimulus("rem",       3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFF);
    applyStimulus("divu",      3'd5, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'h7FFFFFFC);
    applyStimulus("remu",      3'd7, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'h00000001);
    applyStimulus("div_negb",  3'd4, 32'h00000064, 32'hFFFFFFF9, 5'd12, 32'hFFFFFFF2);
    applyStimulus("rem_negb",  3'd6, 32'h00000064, 32'hFFFFFFF9, 5'd13, 32'h00000002);
    applyStimulus("div_z",     3'd4, 32'h12345678, 32'h00000000, 5'd14, 32'hFFFFFFFF);
    applyStimulus("rem_z",     3'd6, 32'h12345678, 32'h00000000, 5'd15, 32'h12345678);
    applyStimulus("divu_z",    3'd5, 32'h12345678, 32'h00000000, 5'd16, 32'hFFFFFFFF);
    applyStimulus("remu_z",    3'd7, 32'h12345678, 32'h00000000, 5'd17, 32'h12345678);
    applyStimulus("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000);
    applyStimulus("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000);
    applyStimulus("divu_big",  3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000);
    applyStimulus("remu_big",  3'd7, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000);

    // Asynchronous reset in the middle of a calculation
    @(posedge clock); #1;
    start = 1'b1; funct3 = 3'd1; SrcAE = 32'h01234567; SrcBE = 32'h89ABCDEF; RdE = 5'd30;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    checkOutput("arst_done", {31'b0, done}, 32'd0);
    checkOutput("arst_result", MduResultE, 32'd0);
    checkOutput("arst_rd", {27'b0, MduRdE}, 32'd0);
    @(posedge clock); #1 reset = 1'b1;
    applyStimulus("post_rst", 3'd0, 32'h00001234, 32'h00000010, 5'd23, 32'h00012340);

    // Flush in cycle 10 of a divide
    @(posedge clock); #1;
    start = 1'b1; funct3 = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd7; RdE = 5'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1 clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
    @(negedge clock);
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("flush_done", {31'b0, done}, 32'd0);
    checkOutput("flush_hold", MduResultE, 32'h00012340);
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) dones++;
    end
    checkOutput("flush_nodone", 32'(dones), 32'd0);
    applyStimulus("after_flush", 3'd4, 32'd1000, 32'd7, 5'd22, 32'd142);

    // start held high through the done cycle must launch only once
    begin
      exp_t e;
      e.result = refResult(3'd0, 32'd3, 32'd5);
      e.rd = 5'd17;
      expQ.push_back(e);
    end
    dones = 0;
    doneCyc = -1;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clock); #1;
      start = (c <= 33); funct3 = 3'd0; SrcAE = 32'd3; SrcBE = 32'd5; RdE = 5'd17;
      @(negedge clock);
      if (done) begin
        dones++;
        doneCyc = c;
      end
      if (c == 34) checkOutput("hold_busy34", {31'b0, busy}, 32'd0);
    end
    checkOutput("hold_dones", 32'(dones), 32'd1);
    checkOutput("hold_donecyc", 32'(doneCyc), 32'd33);
    checkOutput("hold_queue", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
